// File: rtl/poly_regfile_mlane.sv
`default_nettype none
// ============================================================================
// Module   : poly_regfile_mlane
// Brief    : Polynomial register file with two streamed source ports and one
//            streamed destination port, LANES residues per valid/ready beat.
//            Optional macro RF_ZEROIZE_EN clears every register after reset.
// Revision : 1.0 - initial release
// ============================================================================
module poly_regfile_mlane #(
   parameter int NREG    = 8,
   parameter int NCOEFF  = 16,
   parameter int NPRIMES = 4,
   parameter int LANES   = 4,
   parameter int CW      = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    rf_ready,
   input  logic                    op_valid,
   output logic                    op_ready,
   input  logic [$clog2(NREG)-1:0] src0_idx,
   input  logic [$clog2(NREG)-1:0] src1_idx,
   input  logic [$clog2(NREG)-1:0] dst_idx,
   input  logic                    use_src1,
   output logic                    src0_valid,
   input  logic                    src0_ready,
   output logic [LANES*CW-1:0]     src0_data,
   output logic                    src0_last,
   output logic                    src1_valid,
   input  logic                    src1_ready,
   output logic [LANES*CW-1:0]     src1_data,
   output logic                    src1_last,
   input  logic                    dst_valid,
   output logic                    dst_ready,
   input  logic [LANES*CW-1:0]     dst_data,
   input  logic                    dst_last,
   output logic                    len_err
);

   localparam int C_TOTAL = NCOEFF * NPRIMES;
   localparam int C_BEATS = C_TOTAL / LANES;
   localparam int C_DEPTH = NREG * C_BEATS;
   localparam int C_IW    = $clog2(NREG);
   localparam int C_BW    = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
   localparam int C_AW    = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
   localparam int C_DW    = LANES * CW;
   localparam logic [C_BW-1:0] C_LAST_BEAT = C_BW'(C_BEATS - 1);

   generate
      if ((C_TOTAL % LANES) != 0) begin : g_lanes_check
         $error("poly_regfile_mlane: LANES must divide NCOEFF*NPRIMES");
      end
   endgenerate

   typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_STREAM  = 1'b1} rd_state_t;
   typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_COLLECT = 1'b1} wr_state_t;

   // One entry per register beat: address = reg*BEATS + beat
   logic [C_DW-1:0] r_mem [C_DEPTH];

   logic                 w_op_fire;
   logic [1:0]           w_rd_start;
   logic [1:0]           w_rd_ready;
   logic [1:0]           w_rd_act;
   logic [1:0]           w_rd_last;
   logic [1:0][C_IW-1:0] w_rd_idx_in;
   logic [1:0][C_DW-1:0] w_rd_data;

   assign w_op_fire   = op_valid & op_ready;
   assign w_rd_start  = {w_op_fire & use_src1, w_op_fire};
   assign w_rd_ready  = {src1_ready, src0_ready};
   assign w_rd_idx_in = {src1_idx, src0_idx};

   for (genvar g = 0; g < 2; g++) begin : g_rd
      rd_state_t       r_state;
      rd_state_t       w_state_nxt;
      logic [C_BW-1:0] r_beat;
      logic [C_BW-1:0] w_beat_nxt;
      logic [C_IW-1:0] r_idx;
      logic [C_AW-1:0] w_addr;
      logic            w_last;

      assign w_last = (r_state == RD_STREAM) && (r_beat == C_LAST_BEAT);

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_state <= RD_IDLE;
            r_beat  <= '0;
            r_idx   <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_rd_start[g]) begin
               r_idx <= w_rd_idx_in[g];
            end
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_beat_nxt  = r_beat;
         case (r_state)
            RD_IDLE: begin
               if (w_rd_start[g]) begin
                  w_state_nxt = RD_STREAM;
                  w_beat_nxt  = '0;
               end
            end
            RD_STREAM: begin
               if (w_rd_ready[g]) begin
                  if (w_last) begin
                     w_state_nxt = RD_IDLE;
                     w_beat_nxt  = '0;
                  end else begin
                     w_beat_nxt = r_beat + C_BW'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = RD_IDLE;
               w_beat_nxt  = '0;
            end
         endcase
      end

      // Read is combinational from the array, so a same-edge write is seen next cycle
      assign w_addr       = C_AW'(r_idx) * C_AW'(C_BEATS) + C_AW'(r_beat);
      assign w_rd_act[g]  = (r_state == RD_STREAM);
      assign w_rd_last[g] = w_last;
      assign w_rd_data[g] = r_mem[w_addr];
   end

   assign src0_valid = w_rd_act[0];
   assign src0_last  = w_rd_last[0];
   assign src0_data  = w_rd_data[0];
   assign src1_valid = w_rd_act[1];
   assign src1_last  = w_rd_last[1];
   assign src1_data  = w_rd_data[1];

   wr_state_t       r_wr_state;
   wr_state_t       w_wr_state_nxt;
   logic [C_BW-1:0] r_wbeat;
   logic [C_BW-1:0] w_wbeat_nxt;
   logic [C_IW-1:0] r_dst_idx;
   logic            r_len_err;
   logic            w_len_err_nxt;
   logic            w_wr_fire;
   logic            w_wr_final;
   logic [C_AW-1:0] w_wr_addr;

   assign w_wr_fire  = (r_wr_state == WR_COLLECT) & dst_valid;
   assign w_wr_final = (r_wbeat == C_LAST_BEAT);
   assign w_wr_addr  = C_AW'(r_dst_idx) * C_AW'(C_BEATS) + C_AW'(r_wbeat);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_state <= WR_IDLE;
         r_wbeat    <= '0;
         r_dst_idx  <= '0;
         r_len_err  <= 1'b0;
      end else begin
         r_wr_state <= w_wr_state_nxt;
         r_wbeat    <= w_wbeat_nxt;
         r_len_err  <= w_len_err_nxt;
         if (w_op_fire) begin
            r_dst_idx <= dst_idx;
         end
      end
   end

   always_comb begin
      w_wr_state_nxt = r_wr_state;
      w_wbeat_nxt    = r_wbeat;
      w_len_err_nxt  = r_len_err;
      case (r_wr_state)
         WR_IDLE: begin
            if (w_op_fire) begin
               w_wr_state_nxt = WR_COLLECT;
               w_wbeat_nxt    = '0;
            end
         end
         WR_COLLECT: begin
            if (dst_valid) begin
               // Early or missing dst_last both flag a length mismatch
               if (dst_last != w_wr_final) begin
                  w_len_err_nxt = 1'b1;
               end
               if (dst_last || w_wr_final) begin
                  w_wr_state_nxt = WR_IDLE;
                  w_wbeat_nxt    = '0;
               end else begin
                  w_wbeat_nxt = r_wbeat + C_BW'(1);
               end
            end
         end
         default: begin
            w_wr_state_nxt = WR_IDLE;
            w_wbeat_nxt    = '0;
         end
      endcase
   end

   assign dst_ready = (r_wr_state == WR_COLLECT);
   assign len_err   = r_len_err;
   assign op_ready  = rf_ready & ~w_rd_act[0] & ~w_rd_act[1] & ~dst_ready;

   logic            w_mem_we;
   logic [C_AW-1:0] w_mem_addr;
   logic [C_DW-1:0] w_mem_wdata;

`ifdef RF_ZEROIZE_EN
   typedef enum logic [0:0] {CLR_RUN = 1'b0, CLR_DONE = 1'b1} clr_state_t;
   localparam logic [C_AW-1:0] C_LAST_ADDR = C_AW'(C_DEPTH - 1);

   clr_state_t      r_clr_state;
   clr_state_t      w_clr_state_nxt;
   logic [C_AW-1:0] r_clr_addr;
   logic [C_AW-1:0] w_clr_addr_nxt;
   logic            w_clr_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clr_state <= CLR_RUN;
         r_clr_addr  <= '0;
      end else begin
         r_clr_state <= w_clr_state_nxt;
         r_clr_addr  <= w_clr_addr_nxt;
      end
   end

   always_comb begin
      w_clr_state_nxt = r_clr_state;
      w_clr_addr_nxt  = r_clr_addr;
      case (r_clr_state)
         CLR_RUN: begin
            if (r_clr_addr == C_LAST_ADDR) begin
               w_clr_state_nxt = CLR_DONE;
            end else begin
               w_clr_addr_nxt = r_clr_addr + C_AW'(1);
            end
         end
         CLR_DONE: w_clr_state_nxt = CLR_DONE;
         default:  w_clr_state_nxt = CLR_DONE;
      endcase
   end

   // Ops are blocked until clearing ends, so the two write sources never collide
   assign w_clr_we    = (r_clr_state == CLR_RUN);
   assign rf_ready    = (r_clr_state == CLR_DONE);
   assign w_mem_we    = w_wr_fire | w_clr_we;
   assign w_mem_addr  = w_clr_we ? r_clr_addr : w_wr_addr;
   assign w_mem_wdata = w_clr_we ? '0 : dst_data;
`else
   logic r_rf_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rf_ready <= 1'b0;
      end else begin
         r_rf_ready <= 1'b1;
      end
   end

   assign rf_ready    = r_rf_ready;
   assign w_mem_we    = w_wr_fire;
   assign w_mem_addr  = w_wr_addr;
   assign w_mem_wdata = dst_data;
`endif

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_poly_regfile_mlane.sv
`default_nettype none
// Randomised bench for poly_regfile_mlane: a residue-array model predicts
// every stream beat, handshake flag and the sticky length error.
`timescale 1ns/1ps
module tb_poly_regfile_mlane;
   localparam int NREG      = 8;
   localparam int NCOEFF    = 16;
   localparam int NPRIMES   = 4;
   localparam int LANES     = 4;
   localparam int CW        = 32;
   localparam int TOTAL     = NCOEFF * NPRIMES;
   localparam int BEATS     = TOTAL / LANES;
   localparam int IW        = $clog2(NREG);
   localparam int DW        = LANES * CW;
   localparam int N_OPS     = 60;
   localparam int CYCLE_CAP = 30000;

   logic          clk;
   logic          reset;
   logic          rf_ready, op_valid, op_ready, use_src1;
   logic [IW-1:0] src0_idx, src1_idx, dst_idx;
   logic          src0_valid, src0_ready, src0_last;
   logic          src1_valid, src1_ready, src1_last;
   logic [DW-1:0] src0_data, src1_data, dst_data;
   logic          dst_valid, dst_ready, dst_last, len_err;

   poly_regfile_mlane #(
      .NREG(NREG), .NCOEFF(NCOEFF), .NPRIMES(NPRIMES), .LANES(LANES), .CW(CW)
   ) u_dut (
      .clk(clk), .reset(reset), .rf_ready(rf_ready),
      .op_valid(op_valid), .op_ready(op_ready),
      .src0_idx(src0_idx), .src1_idx(src1_idx), .dst_idx(dst_idx), .use_src1(use_src1),
      .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_data(src0_data), .src0_last(src0_last),
      .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_data(src1_data), .src1_last(src1_last),
      .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data), .dst_last(dst_last),
      .len_err(len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: residues indexed by register and flat index
   int unsigned m_mem   [NREG][TOTAL];
   bit          m_known [NREG][TOTAL];
   bit          m_rf, m_act0, m_act1, m_wact, m_len_err, m_tog;
   int          m_b0, m_b1, m_wb, m_s0, m_s1, m_d;
   int          m_opn, m_lmode, m_early, m_clr;
   int          ops_issued, cycles;
   bit          did_mid_reset;
   int          n_tests, n_fail;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_beat(input int r, input int b, output bit known);
      logic [DW-1:0] v;
      v     = '0;
      known = 1'b1;
      for (int l = 0; l < LANES; l++) begin
         v[l*CW +: CW] = m_mem[r][b*LANES + l];
         if (!m_known[r][b*LANES + l]) known = 1'b0;
      end
      return v;
   endfunction

   task automatic compare_outputs();
      bit            k;
      logic [DW-1:0] e;
      check("rf_ready",   DW'(rf_ready),   DW'(m_rf));
      check("op_ready",   DW'(op_ready),   DW'(m_rf & !m_act0 & !m_act1 & !m_wact));
      check("src0_valid", DW'(src0_valid), DW'(m_act0));
      check("src0_last",  DW'(src0_last),  DW'(m_act0 && m_b0 == BEATS-1));
      check("src1_valid", DW'(src1_valid), DW'(m_act1));
      check("src1_last",  DW'(src1_last),  DW'(m_act1 && m_b1 == BEATS-1));
      check("dst_ready",  DW'(dst_ready),  DW'(m_wact));
      check("len_err",    DW'(len_err),    DW'(m_len_err));
      if (m_act0) begin
         e = exp_beat(m_s0, m_b0, k);
         if (k) check("src0_data", src0_data, e);
      end
      if (m_act1) begin
         e = exp_beat(m_s1, m_b1, k);
         if (k) check("src1_data", src1_data, e);
      end
   endtask

   task automatic model_reset();
      m_rf = 0; m_act0 = 0; m_act1 = 0; m_wact = 0; m_len_err = 0;
      m_b0 = 0; m_b1 = 0; m_wb = 0; m_clr = 0;
   endtask

   // Drive this cycle's inputs from the model's view of the current state
   task automatic drive();
      bit dir;
      dir = (m_opn < 12);
      op_valid = (ops_issued < N_OPS) && ($urandom_range(0, 3) != 0);
      case (ops_issued)
         0, 1, 2, 3, 4, 5, 6, 7: begin
            src0_idx = IW'(ops_issued); dst_idx = IW'(ops_issued); src1_idx = 0; use_src1 = 0;
         end
         8:  begin src0_idx = 3; src1_idx = 0; dst_idx = 6; use_src1 = 0; end
         9:  begin src0_idx = 1; src1_idx = 2; dst_idx = 5; use_src1 = 1; end
         10: begin src0_idx = 5; src1_idx = 0; dst_idx = 4; use_src1 = 0; end
         11: begin src0_idx = 4; src1_idx = 5; dst_idx = 0; use_src1 = 1; end
         default: begin
            src0_idx = IW'($urandom_range(0, NREG-1));
            src1_idx = IW'($urandom_range(0, NREG-1));
            dst_idx  = IW'($urandom_range(0, NREG-1));
            use_src1 = 1'($urandom_range(0, 1));
         end
      endcase
      if (m_opn == 9) begin
         src0_ready = 1; src1_ready = m_tog;
      end else if (dir) begin
         src0_ready = 1; src1_ready = 1;
      end else begin
         src0_ready = ($urandom_range(0, 3) != 0);
         src1_ready = ($urandom_range(0, 3) != 0);
      end
      dst_last = 0;
      for (int l = 0; l < LANES; l++) dst_data[l*CW +: CW] = $urandom;
      if (m_wact) begin
         dst_valid = dir ? 1'b1 : ($urandom_range(0, 3) != 0);
         for (int l = 0; l < LANES; l++) begin
            if (m_opn < 8)       dst_data[l*CW +: CW] = CW'(m_opn*1000 + m_wb*LANES + l);
            else if (m_opn == 9) dst_data[l*CW +: CW] = CW'(32'hA000 + m_wb*LANES + l);
         end
         case (m_lmode)
            0:       dst_last = (m_wb == BEATS-1);
            1:       dst_last = (m_wb == m_early);
            default: dst_last = 0;
         endcase
      end else begin
         dst_valid = ($urandom_range(0, 3) == 0);
         dst_last  = 1'($urandom_range(0, 1));
      end
   endtask

   // Move the model to the state after the coming clock edge
   task automatic advance_model();
      bit op_rdy;
      op_rdy = m_rf & !m_act0 & !m_act1 & !m_wact;
      if (m_act0 && src0_ready) begin
         if (m_b0 == BEATS-1) begin m_act0 = 0; m_b0 = 0; end else m_b0++;
      end
      if (m_act1 && src1_ready) begin
         if (m_b1 == BEATS-1) begin m_act1 = 0; m_b1 = 0; end else m_b1++;
      end
      if (m_wact && dst_valid) begin
         for (int l = 0; l < LANES; l++) begin
            m_mem[m_d][m_wb*LANES + l]   = dst_data[l*CW +: CW];
            m_known[m_d][m_wb*LANES + l] = 1;
         end
         if (dst_last != (m_wb == BEATS-1)) m_len_err = 1;
         if (dst_last || m_wb == BEATS-1) begin m_wact = 0; m_wb = 0; end else m_wb++;
      end
      if (op_valid && op_rdy) begin
         m_s0 = int'(src0_idx); m_s1 = int'(src1_idx); m_d = int'(dst_idx);
         m_act0 = 1; m_act1 = use_src1; m_wact = 1;
         m_b0 = 0; m_b1 = 0; m_wb = 0;
         m_opn = ops_issued;
         if (ops_issued == 10) begin
            m_lmode = 1; m_early = 9;
         end else if (ops_issued < 12) begin
            m_lmode = 0;
         end else begin
            m_lmode = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 2));
            m_early = int'($urandom_range(0, BEATS-2));
         end
         ops_issued++;
         m_tog = 1;
      end else begin
         m_tog = ~m_tog;
      end
`ifdef RF_ZEROIZE_EN
      if (m_clr < NREG*BEATS) begin
         for (int l = 0; l < LANES; l++) begin
            m_mem[m_clr / BEATS][(m_clr % BEATS)*LANES + l]   = 0;
            m_known[m_clr / BEATS][(m_clr % BEATS)*LANES + l] = 1;
         end
         m_clr++;
         if (m_clr == NREG*BEATS) m_rf = 1;
      end
`else
      m_rf = 1;
`endif
   endtask

   initial begin
      n_tests = 0; n_fail = 0; ops_issued = 0; cycles = 0;
      did_mid_reset = 0; m_opn = 0; m_lmode = 0; m_early = 0; m_tog = 0;
      m_s0 = 0; m_s1 = 0; m_d = 0;
      for (int r = 0; r < NREG; r++)
         for (int i = 0; i < TOTAL; i++) begin m_mem[r][i] = 0; m_known[r][i] = 0; end
      reset = 1; op_valid = 0; use_src1 = 0;
      src0_idx = 0; src1_idx = 0; dst_idx = 0;
      src0_ready = 0; src1_ready = 0; dst_valid = 0; dst_last = 0; dst_data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_outputs();
      reset = 0;
      #1;
      compare_outputs();

      while ((ops_issued < N_OPS || m_act0 || m_act1 || m_wact) && cycles < CYCLE_CAP) begin
         if (!did_mid_reset && ops_issued > 12 && m_act0 && m_b0 == 7 && m_wact) begin
            did_mid_reset = 1;
            reset = 1;
            model_reset();
            #1;
            compare_outputs();
            @(posedge clk); #1;
            compare_outputs();
            @(posedge clk); #1;
            reset = 0;
            #1;
            compare_outputs();
         end
         drive();
         advance_model();
         @(posedge clk); #1;
         compare_outputs();
         cycles++;
      end
      check("timeout", DW'(cycles < CYCLE_CAP), DW'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
